video_in: RTL and testbench
===========================

Name: video_in

Overview:
- Capture-side counterpart of the video display path: accepts a raster pixel stream (frame_valid/line_valid/8-bit pixel) from the camera/video source.
- Packs pixels into 32-bit words and writes each frame to a RAM buffer as a Wishbone master.
- Signals frame completion with an IRQ pulse.
- Sits between the video source and the WB interconnect; the frame base address is supplied by the register block.

Parameters:
- FIFO_DEPTH, 32, word FIFO depth (power of 2, ≥ 2*BURST_WORDS)
- BURST_WORDS, 8, words per WB burst (BLOCK_SIZE/4)
- ADDR_W, 32, WB address width

Ports:
- p_clk  in  1  single clock for capture and WB master
- p_resetn  in  1  asynchronous active-low reset
- p_enable  in  1  capture enable, sampled at frame start
- p_base_addr  in  32  frame buffer base, word aligned, latched at frame start
- frame_valid  in  1  high during active lines of a frame
- line_valid  in  1  high during active pixels of a line
- pixel_in  in  8  pixel, valid when frame_valid & line_valid
- irq  out  1  one-cycle pulse: frame fully written to RAM
- overflow  out  1  sticky: a word was dropped (FIFO full); cleared at next frame start
- p_wb_DAT_I  in  32  unused
- p_wb_DAT_O  out  32  write data
- p_wb_ADR_O  out  32  byte address
- p_wb_ACK_I  in  1  ack
- p_wb_ERR_I  in  1  error
- p_wb_RTY_I  in  1  retry
- p_wb_CYC_O  out  1  cycle
- p_wb_STB_O  out  1  strobe
- p_wb_LOCK_O  out  1  tied 0
- p_wb_SEL_O  out  4  always 4'hF
- p_wb_WE_O  out  1  1 during writes

Behaviour:
- Reset: irq=0, overflow=0, CYC/STB/WE/LOCK=0, ADR=0, DAT_O=0, SEL=4'hF; FIFO empty; packer cleared; writer in W_IDLE; capture in C_IDLE.
- Capture FSM:
  - C_IDLE→C_FRAME on frame_valid rising edge (registered edge detect) with p_enable=1 and no flush pending. On entry: latch p_base_addr, clear overflow.
  - Rising frame_valid with p_enable=0 or flush pending: the frame is skipped entirely.
  - C_FRAME: each cycle with line_valid=1 writes pixel_in into byte lane k (k=0..3, first pixel → DAT[7:0]). At k=3 the full word pushes into the FIFO the next cycle.
  - Push when FIFO full: word dropped, overflow←1.
  - C_FRAME→C_FLUSH on frame_valid falling edge. A partial word (k≠0) is pushed with upper lanes zero.
  - C_FLUSH→C_IDLE when FIFO empty and writer in W_IDLE. irq pulses high for exactly one cycle on that transition.
- Writer FSM:
  - W_IDLE→W_BUS when FIFO count ≥ BURST_WORDS, or when in C_FLUSH with FIFO non-empty.
  - W_BUS: CYC=STB=WE=1; ADR=current address; DAT_O=FIFO head.
  - On ACK: pop; address+=4; burst count+1.
  - On ERR: pop and advance as for ACK; the word is lost.
  - On RTY: hold ADR/DAT, no pop; STB stays asserted.
  - Burst ends when burst count=BURST_WORDS, or the FIFO becomes empty during flush. Then W_BUS→W_IDLE with CYC/STB/WE←0 in the same cycle as the last ack is seen registered.
  - Minimum one idle cycle between bursts.
- Address: 32-bit byte address, wraps modulo 2^32. The block performs no range check.
- A FIFO push and pop in the same cycle is legal; count is unchanged.
- line_valid is ignored while frame_valid=0.
- Pixels arriving during C_FLUSH/C_IDLE are ignored.
- Asynchronous reset mid-burst: bus signals drop immediately; the partially written frame is abandoned.

Optional Feature:
- VIDEO_IN_DROP_CNT_EN
  - Defined: adds output port drop_count[15:0], a saturating count of dropped words (FIFO overflow plus ERR-terminated words). Cleared at frame start; holds 16'hFFFF on saturation.
  - Undefined: port and counter absent; overflow behaviour unchanged.

Decomposition:
- video_pkg holds:
  - constants RAM_BASE, RAM_SIZE, IMAGE_WIDTH=640, IMAGE_HEIGHT=480, BLOCK_SIZE=32
  - typedef enum capture_state_t {C_IDLE,C_FRAME,C_FLUSH}
  - typedef enum writer_state_t {W_IDLE,W_BUS}
- Sub-module video_in_fifo: synchronous 32-bit word FIFO with push/pop/full/empty/count. Instantiated once.

Test Plan:
- 640x480 frame, base 0x41000000, ACK every cycle → 76800 writes covering 0x41000000..0x4104AFFC in order; exactly one irq; overflow=0.
- Pixels 0x01,0x02,0x03,0x04,0x05,0x06 as a 6-pixel frame → writes 0x04030201@base, 0x00000605@base+4 during flush; then irq.
- ACK held low for 2000 cycles during a frame with FIFO_DEPTH=32 → overflow=1, no irq before flush ends; drop_count>0 if VIDEO_IN_DROP_CNT_EN.
- RTY asserted on 3rd word of a burst for 2 cycles → same ADR/DAT re-presented; no address skipped; total word count exact.
- p_enable=0 at frame start → no WB cycles, no irq. Rising frame_valid during C_FLUSH → that frame skipped.
- p_resetn asserted mid-burst → CYC/STB/WE=0 asynchronously. Next enabled frame restarts at the newly latched base.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and state types for the video capture path.
package video_pkg;
  localparam logic [31:0] RAM_BASE     = 32'h4100_0000;
  localparam logic [31:0] RAM_SIZE     = 32'h0010_0000;
  localparam int          IMAGE_WIDTH  = 640;
  localparam int          IMAGE_HEIGHT = 480;
  localparam int          BLOCK_SIZE   = 32;

  typedef enum logic [1:0] {C_IDLE, C_FRAME, C_FLUSH} capture_state_t;
  typedef enum logic       {W_IDLE, W_BUS}            writer_state_t;
endpackage

// File: rtl/video_in_fifo.sv
// Synchronous word FIFO; pushes when full and pops when empty are ignored.
module video_in_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 32
) (
  input  logic                     p_clk,
  input  logic                     p_resetn,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge p_clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/video_in.sv
// Raster capture: packs 8-bit pixels into words, bursts them to RAM as a WB master.
// Define VIDEO_IN_DROP_CNT_EN to add the saturating drop_count output.
module video_in
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH  = 32,
  parameter int BURST_WORDS = BLOCK_SIZE / 4,
  parameter int ADDR_W      = 32
) (
  input  logic              p_clk,
  input  logic              p_resetn,
  input  logic              p_enable,
  input  logic [ADDR_W-1:0] p_base_addr,
  input  logic              frame_valid,
  input  logic              line_valid,
  input  logic [7:0]        pixel_in,
  output logic              irq,
  output logic              overflow,
  input  logic [31:0]       p_wb_DAT_I,
  output logic [31:0]       p_wb_DAT_O,
  output logic [ADDR_W-1:0] p_wb_ADR_O,
  input  logic              p_wb_ACK_I,
  input  logic              p_wb_ERR_I,
  input  logic              p_wb_RTY_I,
  output logic              p_wb_CYC_O,
  output logic              p_wb_STB_O,
  output logic              p_wb_LOCK_O,
  output logic [3:0]        p_wb_SEL_O,
  output logic              p_wb_WE_O
`ifdef VIDEO_IN_DROP_CNT_EN
  , output logic [15:0]     drop_count
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_WORDS) + 1;

  capture_state_t cstate;
  writer_state_t  wstate;

  logic          fv_q, fv_rise, fv_fall, start;
  logic [1:0]    lane;
  logic [23:0]   pack;
  logic          push_vld;
  logic [31:0]   push_dat;
  logic [31:0]   f_head;
  logic          f_full, f_empty;
  logic [CW-1:0] f_count;
  logic [BW-1:0] burst_cnt;
  logic          wb_bus, xfer, last, burst_go, flush_done, drop;
  logic          unused_dat;

  assign unused_dat = ^p_wb_DAT_I;

  assign fv_rise    = frame_valid & ~fv_q;
  assign fv_fall    = ~frame_valid & fv_q;
  assign start      = fv_rise & p_enable & (cstate == C_IDLE);
  assign wb_bus     = (wstate == W_BUS);
  // ERR consumes the word just like ACK; RTY leaves everything in place.
  assign xfer       = wb_bus & (p_wb_ACK_I | p_wb_ERR_I);
  assign last       = (burst_cnt == BW'(BURST_WORDS - 1)) | ((f_count == CW'(1)) & ~push_vld);
  assign burst_go   = (f_count >= CW'(BURST_WORDS)) | ((cstate == C_FLUSH) & ~f_empty);
  assign flush_done = (cstate == C_FLUSH) & f_empty & ~wb_bus & ~push_vld;
  assign drop       = push_vld & f_full;

  assign p_wb_CYC_O  = wb_bus;
  assign p_wb_STB_O  = wb_bus;
  assign p_wb_WE_O   = wb_bus;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign p_wb_DAT_O  = wb_bus ? f_head : 32'h0;

  video_in_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .p_clk   (p_clk),
    .p_resetn(p_resetn),
    .push    (push_vld),
    .wdata   (push_dat),
    .pop     (xfer),
    .rdata   (f_head),
    .full    (f_full),
    .empty   (f_empty),
    .count   (f_count)
  );

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      cstate   <= C_IDLE;
      fv_q     <= 1'b0;
      lane     <= '0;
      pack     <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      fv_q     <= frame_valid;
      push_vld <= 1'b0;
      irq      <= 1'b0;
      if (drop) overflow <= 1'b1;
      unique case (cstate)
        C_IDLE: if (start) begin
          cstate   <= C_FRAME;
          overflow <= 1'b0;
          lane     <= '0;
          pack     <= '0;
        end
        C_FRAME: if (fv_fall) begin
          cstate <= C_FLUSH;
          lane   <= '0;
          if (lane != 2'd0) begin
            push_vld <= 1'b1;
            push_dat <= {8'h0, pack};
          end
        end else if (frame_valid & line_valid) begin
          lane <= lane + 2'd1;
          unique case (lane)
            2'd0: pack        <= {16'h0, pixel_in};
            2'd1: pack[15:8]  <= pixel_in;
            2'd2: pack[23:16] <= pixel_in;
            2'd3: begin
              push_vld <= 1'b1;
              push_dat <= {pixel_in, pack};
            end
          endcase
        end
        C_FLUSH: if (flush_done) begin
          cstate <= C_IDLE;
          irq    <= 1'b1;
        end
        default: cstate <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      wstate     <= W_IDLE;
      p_wb_ADR_O <= '0;
      burst_cnt  <= '0;
    end else begin
      if (start) p_wb_ADR_O <= p_base_addr;
      unique case (wstate)
        W_IDLE: if (burst_go) begin
          wstate    <= W_BUS;
          burst_cnt <= '0;
        end
        W_BUS: if (xfer) begin
          p_wb_ADR_O <= p_wb_ADR_O + ADDR_W'(4);
          burst_cnt  <= burst_cnt + 1'b1;
          if (last) wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

`ifdef VIDEO_IN_DROP_CNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 17'(drop) + 17'(wb_bus & p_wb_ERR_I & ~p_wb_ACK_I);

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn)  drop_count <= '0;
    else if (start) drop_count <= '0;
    else            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_video_in.sv
// Directed/randomized bench for video_in with a WB slave and a byte-stream reference model.
module tb_video_in;
  logic        p_clk = 0, p_resetn = 0, p_enable = 0;
  logic        frame_valid = 0, line_valid = 0;
  logic [31:0] p_base_addr = 0;
  logic [7:0]  pixel_in = 0;
  logic        irq, overflow;
  logic [31:0] p_wb_DAT_I = 0, p_wb_DAT_O, p_wb_ADR_O;
  logic        p_wb_ACK_I = 0, p_wb_ERR_I = 0, p_wb_RTY_I = 0;
  logic        p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O;
  logic [3:0]  p_wb_SEL_O;
`ifdef VIDEO_IN_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  always #5 p_clk = ~p_clk;

  video_in #(.FIFO_DEPTH(32), .BURST_WORDS(8), .ADDR_W(32)) dut (
    .p_clk(p_clk), .p_resetn(p_resetn), .p_enable(p_enable), .p_base_addr(p_base_addr),
    .frame_valid(frame_valid), .line_valid(line_valid), .pixel_in(pixel_in),
    .irq(irq), .overflow(overflow),
    .p_wb_DAT_I(p_wb_DAT_I), .p_wb_DAT_O(p_wb_DAT_O), .p_wb_ADR_O(p_wb_ADR_O),
    .p_wb_ACK_I(p_wb_ACK_I), .p_wb_ERR_I(p_wb_ERR_I), .p_wb_RTY_I(p_wb_RTY_I),
    .p_wb_CYC_O(p_wb_CYC_O), .p_wb_STB_O(p_wb_STB_O), .p_wb_LOCK_O(p_wb_LOCK_O),
    .p_wb_SEL_O(p_wb_SEL_O), .p_wb_WE_O(p_wb_WE_O)
`ifdef VIDEO_IN_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  int passed = 0, total = 0;
  int irq_cnt = 0, exp_irq = 0;
  int nw = 0, rty_at = -1, rty_left = 0, err_at = -1, ack_pct = 100;
  bit ack_en = 1;
  logic [31:0] obs_adr[$], obs_dat[$], rty_adr[$], rty_dat[$], exp_adr[$], exp_dat[$];
  bit          obs_err[$];
  logic [7:0]  px_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // WB slave: decides the response half a cycle ahead of the sampling edge.
  always @(negedge p_clk) begin
    p_wb_ACK_I = 0; p_wb_ERR_I = 0; p_wb_RTY_I = 0;
    if (irq) irq_cnt++;
    if (p_wb_CYC_O && p_wb_STB_O) begin
      if (rty_left > 0 && nw == rty_at) begin
        p_wb_RTY_I = 1;
        rty_left--;
        rty_adr.push_back(p_wb_ADR_O);
        rty_dat.push_back(p_wb_DAT_O);
      end else if (ack_en && int'($urandom_range(99)) < ack_pct) begin
        if (nw == err_at) p_wb_ERR_I = 1; else p_wb_ACK_I = 1;
        obs_adr.push_back(p_wb_ADR_O);
        obs_dat.push_back(p_wb_DAT_O);
        obs_err.push_back(nw == err_at);
        nw++;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge p_clk); #1; end
  endtask

  task automatic clr();
    obs_adr.delete(); obs_dat.delete(); obs_err.delete();
    rty_adr.delete(); rty_dat.delete(); exp_adr.delete(); exp_dat.delete(); px_q.delete();
    nw = 0; rty_at = -1; rty_left = 0; err_at = -1; ack_pct = 100; ack_en = 1;
  endtask

  // Pixels are presented only after frame_valid has been high for two cycles.
  task automatic drive_frame(int lines, int width, bit seq, bit rec);
    int k = 0;
    line_valid = 1; pixel_in = 8'($urandom); tick(2);
    line_valid = 0; frame_valid = 1; tick(2);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < width; p++) begin
        line_valid = 1;
        pixel_in = seq ? 8'(k + 1) : 8'($urandom);
        k++;
        if (rec) px_q.push_back(pixel_in);
        tick();
      end
      line_valid = 0; pixel_in = 8'($urandom); tick(2);
    end
    frame_valid = 0; tick();
  endtask

  // Reference: byte stream, little-endian 4-byte packing, zero-padded tail, consecutive addresses.
  task automatic build_exp(logic [31:0] base, int maxw);
    int nwd = (px_q.size() + 3) / 4;
    if (nwd > maxw) nwd = maxw;
    for (int i = 0; i < nwd; i++) begin
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < px_q.size()) w[8*b +: 8] = px_q[4*i+b];
      exp_adr.push_back(base + 32'(4 * i));
      exp_dat.push_back(w);
    end
  endtask

  task automatic cmp_writes(string tag);
    check({tag, "_nwr"}, obs_adr.size(), exp_adr.size());
    for (int i = 0; i < exp_adr.size() && i < obs_adr.size(); i++) begin
      check($sformatf("%s_adr%0d", tag, i), obs_adr[i], exp_adr[i]);
      check($sformatf("%s_dat%0d", tag, i), obs_dat[i], exp_dat[i]);
    end
  endtask

  task automatic wait_irq(int target, int budget);
    int c = 0;
    while (irq_cnt < target && c < budget) begin tick(); c++; end
    tick(5);
    check("irq_count", irq_cnt, target);
  endtask

  initial begin
    logic [31:0] base;
    tick(3);
    check("rst_irq", irq, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cyc", p_wb_CYC_O, 0);
    check("rst_stb", p_wb_STB_O, 0);
    check("rst_we", p_wb_WE_O, 0);
    check("rst_lock", p_wb_LOCK_O, 0);
    check("rst_adr", p_wb_ADR_O, 0);
    check("rst_dat", p_wb_DAT_O, 0);
    check("rst_sel", p_wb_SEL_O, 4'hF);
    p_resetn = 1; tick(2);

    // 6-pixel frame with a partial tail word
    clr(); base = 32'h4100_0000; p_base_addr = base; p_enable = 1;
    drive_frame(1, 6, 1, 1);
    build_exp(base, 1000); exp_irq++;
    wait_irq(exp_irq, 500);
    cmp_writes("seq6");
    check("seq6_w0", exp_dat[0], 32'h0403_0201);
    check("seq6_w1", exp_dat[1], 32'h0000_0605);
    check("seq6_ovf", overflow, 0);

    // random frames, random ACK stalls, one base that wraps past 2^32
    for (int it = 0; it < 3; it++) begin
      clr(); ack_pct = int'($urandom_range(100, 50));
      base = (it == 2) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      p_base_addr = base;
      drive_frame(int'($urandom_range(5, 1)), int'($urandom_range(30, 1)), 0, 1);
      build_exp(base, 1000); exp_irq++;
      wait_irq(exp_irq, 3000);
      cmp_writes($sformatf("rnd%0d", it));
      check("rnd_ovf", overflow, 0);
    end

    // RTY on the 3rd word of a burst for 2 cycles
    clr(); rty_at = 2; rty_left = 2; base = 32'h4100_1000; p_base_addr = base;
    drive_frame(2, 20, 0, 1);
    build_exp(base, 1000); exp_irq++;
    wait_irq(exp_irq, 1000);
    cmp_writes("rty");
    check("rty_cnt", rty_adr.size(), 2);
    for (int i = 0; i < rty_adr.size(); i++) begin
      check("rty_adr", rty_adr[i], exp_adr[2]);
      check("rty_dat", rty_dat[i], exp_dat[2]);
    end

    // ERR on word 4: consumed and addressing advances
    clr(); err_at = 4; base = 32'h4100_2000; p_base_addr = base;
    drive_frame(3, 12, 0, 1);
    build_exp(base, 1000); exp_irq++;
    wait_irq(exp_irq, 1000);
    cmp_writes("err");
    check("err_flag", (obs_err.size() > 4) ? 32'(obs_err[4]) : 32'd0, 1);
`ifdef VIDEO_IN_DROP_CNT_EN
    check("err_drops", drop_count, 1);
`endif

    // capture disabled at frame start
    clr(); p_enable = 0;
    drive_frame(2, 16, 0, 0);
    tick(60);
    check("dis_nwr", obs_adr.size(), 0);
    check("dis_irq", irq_cnt, exp_irq);
    p_enable = 1;

    // ACK held off: FIFO keeps the first 32 words, the rest are dropped
    clr(); ack_en = 0; base = 32'h4100_3000; p_base_addr = base;
    drive_frame(8, 64, 0, 1);
    tick(50);
    check("ovf_set", overflow, 1);
    check("ovf_no_irq", irq_cnt, exp_irq);
`ifdef VIDEO_IN_DROP_CNT_EN
    check("ovf_drops", drop_count, 96);
`endif
    ack_en = 1;
    build_exp(base, 32); exp_irq++;
    wait_irq(exp_irq, 2000);
    cmp_writes("ovf");

    // frame B rising during flush of frame A is skipped
    clr(); ack_en = 0; base = 32'h4100_4000; p_base_addr = base;
    drive_frame(3, 8, 0, 1);
    check("ovf_clear", overflow, 0);
    tick(5);
    p_base_addr = 32'h4200_0000;
    drive_frame(2, 8, 0, 0);
    ack_en = 1;
    build_exp(base, 1000); exp_irq++;
    wait_irq(exp_irq, 1000);
    tick(30);
    check("skip_irq", irq_cnt, exp_irq);
    cmp_writes("skip");

    // reset mid-burst, then restart at a fresh base
    clr(); ack_en = 0; p_base_addr = 32'h4100_5000;
    frame_valid = 1; tick(2);
    for (int p = 0; p < 40; p++) begin line_valid = 1; pixel_in = 8'($urandom); tick(); end
    line_valid = 0;
    for (int c = 0; c < 100 && !p_wb_CYC_O; c++) tick();
    check("pre_rst_cyc", p_wb_CYC_O, 1);
    #2 p_resetn = 0;
    #1;
    check("arst_cyc", p_wb_CYC_O, 0);
    check("arst_stb", p_wb_STB_O, 0);
    check("arst_we", p_wb_WE_O, 0);
    frame_valid = 0; tick(3);
    p_resetn = 1; tick(2);
    clr(); base = 32'h4100_8000; p_base_addr = base;
    drive_frame(2, 10, 0, 1);
    build_exp(base, 1000); exp_irq++;
    wait_irq(exp_irq, 1000);
    cmp_writes("rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
